sig_gen_mixer: RTL

//  Complex mixer directly downstream of sig_gen: joins an IQ sample stream with the sig_gen LO stream (cosine, sine)
//  and outputs the frequency-shifted product (i+jq)*(cos±j*sin). 3-stage pipeline, valid/ready on every interface,

---
 rtl/caf_pkg.sv | 38 +++
 rtl/sig_gen_mixer_cmul.sv | 103 ++++++++++
 rtl/sig_gen_mixer.sv | 80 ++++++++
 3 files changed

// File: rtl/caf_pkg.sv
// Shared definitions for the CAF front end: the mixer sum-width derivation,
// the output saturation helper and the stage-valid type.
package caf_pkg;

    // Widest intermediate that the saturation helper accepts.
    localparam int MAX_W = 64;

    // Width of a complex-multiply sum: one full product plus one carry bit.
    function automatic int mixer_w(input int iq_bits, input int lo_bits);
        return iq_bits + lo_bits + 1;
    endfunction

    // Sum width for the default 8/8 configuration.
    localparam int W_DEFAULT = mixer_w(8, 8);

    // One valid bit travelling alongside each pipeline stage.
    typedef logic stage_valid_t;

    // Clamp a signed value to the range of an out_bits-wide signed number.
    function automatic logic signed [MAX_W-1:0] mixer_sat(
        input logic signed [MAX_W-1:0] x,
        input int                      out_bits
    );
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        one = 1;
        hi  = (one <<< (out_bits - 1)) - one;
        lo  = -(one <<< (out_bits - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/sig_gen_mixer_cmul.sv
// Back half of the mixer pipeline: partial products (S2), complex add/sub
// with scaling and saturation into the output register (S3).
// Build option: SIG_GEN_MIXER_ROUND_EN selects round-half-up instead of floor.
module sig_gen_mixer_cmul
    import caf_pkg::*;
#(
    parameter int IQ_BITS  = 8,
    parameter int LO_BITS  = 8,
    parameter int OUT_BITS = 8,
    parameter int CONJ     = 0
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       en,
    input  logic                       v1,
    input  logic signed [IQ_BITS-1:0]  i,
    input  logic signed [IQ_BITS-1:0]  q,
    input  logic signed [LO_BITS-1:0]  lo_cos,
    input  logic signed [LO_BITS-1:0]  lo_sin,
    output logic                       m_tvalid,
    output logic signed [OUT_BITS-1:0] m_i,
    output logic signed [OUT_BITS-1:0] m_q
);

    localparam int P     = IQ_BITS + LO_BITS;
    localparam int W     = mixer_w(IQ_BITS, LO_BITS);
    localparam int SHIFT = W - 1 - OUT_BITS;
`ifdef SIG_GEN_MIXER_ROUND_EN
    localparam logic signed [W-1:0] RND = W'(1 << (SHIFT - 1));
`endif

    logic signed [P-1:0] p_ic, p_qs, p_is, p_qc;
    logic signed [P-1:0] pp_ic, pp_qs, pp_is, pp_qc;
    stage_valid_t        v2;
    logic signed [W-1:0] re_sum, im_sum;
    logic signed [W-1:0] re_sh, im_sh;
    logic signed [OUT_BITS-1:0] re_out, im_out;

    // Four partial products, operands sign-extended to the full product width.
    always_comb begin
        p_ic = P'(i) * P'(lo_cos);
        p_qs = P'(q) * P'(lo_sin);
        p_is = P'(i) * P'(lo_sin);
        p_qc = P'(q) * P'(lo_cos);
    end

    // S2: register partial products; frozen together with v2 while stalled.
    // NOTE: sequential state uses <= so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v2    <= 1'b0;
            pp_ic <= '0;
            pp_qs <= '0;
            pp_is <= '0;
            pp_qc <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                pp_ic <= p_ic;
                pp_qs <= p_qs;
                pp_is <= p_is;
                pp_qc <= p_qc;
            end
        end
    end

    // Complex add/sub for the chosen rotation sense, then scale and saturate.
    // NOTE: every always_comb output is assigned on all paths so no latch forms.
    always_comb begin
        if (CONJ != 0) begin
            re_sum = W'(pp_ic) + W'(pp_qs);
            im_sum = W'(pp_qc) - W'(pp_is);
        end else begin
            re_sum = W'(pp_ic) - W'(pp_qs);
            im_sum = W'(pp_is) + W'(pp_qc);
        end
`ifdef SIG_GEN_MIXER_ROUND_EN
        re_sh = (re_sum + RND) >>> SHIFT;
        im_sh = (im_sum + RND) >>> SHIFT;
`else
        re_sh = re_sum >>> SHIFT;
        im_sh = im_sum >>> SHIFT;
`endif
        re_out = OUT_BITS'(mixer_sat(MAX_W'(re_sh), OUT_BITS));
        im_out = OUT_BITS'(mixer_sat(MAX_W'(im_sh), OUT_BITS));
    end

    // S3: output register, held with its valid until downstream accepts.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_tvalid <= 1'b0;
            m_i      <= '0;
            m_q      <= '0;
        end else if (en) begin
            m_tvalid <= v2;
            if (v2) begin
                m_i <= re_out;
                m_q <= im_out;
            end
        end
    end

endmodule

// File: rtl/sig_gen_mixer.sv
// Complex mixer: joins an IQ stream with the sig_gen LO stream and emits
// (i+jq)*(cos +/- j*sin) through a 3-stage, fully back-pressured pipeline.
// Build option: SIG_GEN_MIXER_ROUND_EN (round-half-up scaling in the cmul stage).
module sig_gen_mixer
    import caf_pkg::*;
#(
    parameter int IQ_BITS  = 8,
    parameter int LO_BITS  = 8,
    parameter int OUT_BITS = 8,
    parameter int CONJ     = 0
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       s_iq_tvalid,
    output logic                       s_iq_tready,
    input  logic signed [IQ_BITS-1:0]  s_iq_i,
    input  logic signed [IQ_BITS-1:0]  s_iq_q,
    input  logic                       s_lo_tvalid,
    output logic                       s_lo_tready,
    input  logic signed [LO_BITS-1:0]  s_lo_cos,
    input  logic signed [LO_BITS-1:0]  s_lo_sin,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic signed [OUT_BITS-1:0] m_i,
    output logic signed [OUT_BITS-1:0] m_q
);

    logic                      en;
    logic                      fire;
    stage_valid_t              v1;
    logic signed [IQ_BITS-1:0] r_i, r_q;
    logic signed [LO_BITS-1:0] r_cos, r_sin;

    // The whole pipeline advances only when the output slot is free or leaving;
    // each ready is gated by the other stream's valid so both are consumed as a pair.
    assign en          = !m_tvalid || m_tready;
    assign fire        = s_iq_tvalid && s_lo_tvalid && en;
    assign s_iq_tready = s_lo_tvalid && en;
    assign s_lo_tready = s_iq_tvalid && en;

    // S1: capture the joined IQ/LO pair on fire.
    // NOTE: data registers are reset too, so outputs read 0 right after reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v1    <= 1'b0;
            r_i   <= '0;
            r_q   <= '0;
            r_cos <= '0;
            r_sin <= '0;
        end else if (en) begin
            v1 <= fire;
            if (fire) begin
                r_i   <= s_iq_i;
                r_q   <= s_iq_q;
                r_cos <= s_lo_cos;
                r_sin <= s_lo_sin;
            end
        end
    end

    sig_gen_mixer_cmul #(
        .IQ_BITS  (IQ_BITS),
        .LO_BITS  (LO_BITS),
        .OUT_BITS (OUT_BITS),
        .CONJ     (CONJ)
    ) u_cmul (
        .clk      (clk),
        .n_reset  (n_reset),
        .en       (en),
        .v1       (v1),
        .i        (r_i),
        .q        (r_q),
        .lo_cos   (r_cos),
        .lo_sin   (r_sin),
        .m_tvalid (m_tvalid),
        .m_i      (m_i),
        .m_q      (m_q)
    );

endmodule
